multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the 16-bit datapath. Directly upstream of the ALU:

---
 rtl/multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle control FSM sitting directly upstream of the ALU of the 16-bit
//   datapath. It decodes the instruction register, steers the ALU operand
//   muxes and operation, and drives the PC, memory, IR and register-file
//   enables. Memory accesses complete on a MemReady handshake; a wait watchdog
//   abandons an access that stalls too long and restarts at FETCH.
//
//   Parameters
//     pOpLsb       LSB of the 4-bit opcode field in the instruction
//     pWaitLimit   cycles allowed without MemReady before abort (1..16)
//
//   Ports
//     i_clock          single clock, rising edge
//     i_reset          synchronous, active-high
//     i_instruction    IR contents (valid from DECODE onward)
//     i_mem_ready      memory completes the current request this cycle
//     o_alu_sel_a      0=PC, 1=ReadData1
//     o_alu_sel_b      00=ReadData2, 01=const 1, 10=sign-ext immediate
//     o_alu_op         00=add, 01=sub, 10=R-type funct
//     o_pc_write       unconditional PC load
//     o_pc_write_cond  PC load qualified externally by ALU Zero
//     o_pc_source      0=ALU result, 1=ALUOut
//     o_iord           memory address: 0=PC, 1=ALUOut
//     o_mem_read       memory read request
//     o_mem_write      memory write request
//     o_ir_write       load IR
//     o_reg_dst        0=rt, 1=rd
//     o_mem_to_reg     write-back source: 0=ALUOut, 1=MDR
//     o_reg_write      register-file write
//     o_mem_timeout    one-cycle pulse on watchdog abort
//     o_illegal_op     sticky illegal-opcode flag
//
//   Build option
//     ILLEGAL_TRAP_EN  illegal opcodes park the FSM in TRAP and set
//                      o_illegal_op; otherwise they execute as a NOP.
//
//   state  | meaning
//   FETCH  | read instruction at PC, PC+1 on completion
//   DECODE | decode opcode, compute branch target into ALUOut
//   REXEC  | R-type ALU operation
//   RWB    | R-type write-back to rd
//   IEXEC  | ADDI ALU operation
//   IWB    | ADDI write-back to rt
//   MADDR  | LW/SW effective address
//   MREAD  | LW memory read, wait for MemReady
//   LWB    | LW write-back of MDR to rt
//   MWRITE | SW memory write, wait for MemReady
//   BRANCH | BEQ compare, conditional PC load
//   TRAP   | illegal opcode, idle until reset (ILLEGAL_TRAP_EN only)

module multicycle_ctrl #(
  parameter int pOpLsb     = 12,
  parameter int pWaitLimit = 15
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [15:0] i_instruction,
  input  logic        i_mem_ready,
  output logic        o_alu_sel_a,
  output logic [1:0]  o_alu_sel_b,
  output logic [1:0]  o_alu_op,
  output logic        o_pc_write,
  output logic        o_pc_write_cond,
  output logic        o_pc_source,
  output logic        o_iord,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_ir_write,
  output logic        o_reg_dst,
  output logic        o_mem_to_reg,
  output logic        o_reg_write,
  output logic        o_mem_timeout,
  output logic        o_illegal_op
);

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_REXEC,
    ST_RWB,
    ST_IEXEC,
    ST_IWB,
    ST_MADDR,
    ST_MREAD,
    ST_LWB,
    ST_MWRITE,
    ST_BRANCH
`ifdef ILLEGAL_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  localparam logic [3:0] cOpR    = 4'h0;
  localparam logic [3:0] cOpLw   = 4'h1;
  localparam logic [3:0] cOpSw   = 4'h2;
  localparam logic [3:0] cOpBeq  = 4'h3;
  localparam logic [3:0] cOpAddi = 4'h4;
  localparam logic [3:0] cLimitM1 = 4'(pWaitLimit - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_wait_cnt;
  logic [3:0] w_wait_next;
  logic [3:0] w_op;
  logic       w_mem_state;
  logic       w_timeout;
  logic       w_unused_instr;

  assign w_op           = i_instruction[pOpLsb+3:pOpLsb];
  assign w_unused_instr = ^i_instruction;
  assign w_mem_state    = (r_state == ST_FETCH) || (r_state == ST_MREAD) ||
                          (r_state == ST_MWRITE);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_wait_next = '0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_FETCH:  if (i_mem_ready) w_next = ST_DECODE;
      ST_DECODE: begin
        case (w_op)
          cOpR:         w_next = ST_REXEC;
          cOpLw, cOpSw: w_next = ST_MADDR;
          cOpBeq:       w_next = ST_BRANCH;
          cOpAddi:      w_next = ST_IEXEC;
`ifdef ILLEGAL_TRAP_EN
          default:      w_next = ST_TRAP;
`else
          default:      w_next = ST_FETCH;
`endif
        endcase
      end
      ST_REXEC:  w_next = ST_RWB;
      ST_RWB:    w_next = ST_FETCH;
      ST_IEXEC:  w_next = ST_IWB;
      ST_IWB:    w_next = ST_FETCH;
      ST_MADDR:  w_next = (w_op == cOpSw) ? ST_MWRITE : ST_MREAD;
      ST_MREAD:  if (i_mem_ready) w_next = ST_LWB;
      ST_LWB:    w_next = ST_FETCH;
      ST_MWRITE: if (i_mem_ready) w_next = ST_FETCH;
      ST_BRANCH: w_next = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP:   w_next = ST_TRAP;
`endif
      default:   w_next = ST_FETCH;
    endcase
    // Watchdog overrides the hold; MemReady in the limit cycle still completes.
    // A timeout in FETCH re-enters FETCH with a cleared count.
    if (w_mem_state && !i_mem_ready) begin
      if (r_wait_cnt == cLimitM1) begin
        w_timeout = 1'b1;
        w_next    = ST_FETCH;
      end else begin
        w_wait_next = 4'(r_wait_cnt + 4'd1);
      end
    end
  end

  always_comb begin
    o_alu_sel_a     = 1'b0;
    o_alu_sel_b     = 2'b00;
    o_alu_op        = 2'b00;
    o_pc_write      = 1'b0;
    o_pc_write_cond = 1'b0;
    o_pc_source     = 1'b0;
    o_iord          = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_ir_write      = 1'b0;
    o_reg_dst       = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_reg_write     = 1'b0;
    o_mem_timeout   = 1'b0;
    if (!i_reset) begin
      o_mem_timeout = w_timeout;
      case (r_state)
        ST_FETCH: begin
          o_mem_read  = 1'b1;
          o_alu_sel_b = 2'b01;
          o_ir_write  = i_mem_ready;
          o_pc_write  = i_mem_ready;
        end
        ST_DECODE: o_alu_sel_b = 2'b10;
        ST_REXEC: begin
          o_alu_sel_a = 1'b1;
          o_alu_op    = 2'b10;
        end
        ST_RWB: begin
          o_reg_write = 1'b1;
          o_reg_dst   = 1'b1;
        end
        ST_IEXEC, ST_MADDR: begin
          o_alu_sel_a = 1'b1;
          o_alu_sel_b = 2'b10;
        end
        ST_IWB: o_reg_write = 1'b1;
        ST_MREAD: begin
          o_mem_read = 1'b1;
          o_iord     = 1'b1;
        end
        ST_LWB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
        end
        ST_MWRITE: begin
          o_mem_write = 1'b1;
          o_iord      = 1'b1;
        end
        ST_BRANCH: begin
          o_alu_sel_a     = 1'b1;
          o_alu_op        = 2'b01;
          o_pc_write_cond = 1'b1;
          o_pc_source     = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_illegal <= 1'b0;
    else if (r_state == ST_DECODE && w_next == ST_TRAP)
      r_illegal <= 1'b1;
  end
  assign o_illegal_op = r_illegal;
`else
  assign o_illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  localparam int LIMIT = 15;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [15:0] ins;
  logic        sel_a, pcw, pcwc, pcsrc, iord, mrd, mwr, irw, dst, m2r, rw, to, ill;
  logic [1:0]  sel_b, alu_op;
  logic [16:0] act;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.pOpLsb(12), .pWaitLimit(LIMIT)) dut (
    .i_clock(clk), .i_reset(rst), .i_instruction(ins), .i_mem_ready(rdy),
    .o_alu_sel_a(sel_a), .o_alu_sel_b(sel_b), .o_alu_op(alu_op),
    .o_pc_write(pcw), .o_pc_write_cond(pcwc), .o_pc_source(pcsrc),
    .o_iord(iord), .o_mem_read(mrd), .o_mem_write(mwr), .o_ir_write(irw),
    .o_reg_dst(dst), .o_mem_to_reg(m2r), .o_reg_write(rw),
    .o_mem_timeout(to), .o_illegal_op(ill)
  );

  assign act = {sel_a, sel_b, alu_op, pcw, pcwc, pcsrc, iord, mrd, mwr, irw, dst, m2r, rw, to, ill};

  function automatic logic [16:0] ov(input bit a, input bit [1:0] b, input bit [1:0] op,
      input bit pw, input bit pwc, input bit ps, input bit io, input bit mr, input bit mw,
      input bit ir, input bit rd, input bit mt, input bit rwr, input bit t, input bit il);
    return {a, b, op, pw, pwc, ps, io, mr, mw, ir, rd, mt, rwr, t, il};
  endfunction

  logic [16:0] V_ZERO, V_FETCH0, V_FETCH1, V_DECODE, V_REXEC, V_RWB, V_BRANCH,
               V_MADDR, V_MREAD, V_LWB, V_MWRITE, V_FETCH_TO, V_ILL;
  localparam logic [16:0] M_ALL = '1;
  localparam logic [16:0] M_TO  = 17'h00026; // timeout, IRWrite, RegWrite

  task automatic cyc(input bit r, input bit d, input logic [15:0] i,
                     input logic [16:0] e, input logic [16:0] m, input string nm);
    rst = r; rdy = d; ins = i;
    @(negedge clk);
    total++;
    if ((act & m) !== (e & m)) begin
      bad++;
      $display("FAIL %s: got %h expected %h (mask %h)", nm, act, e, m);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: phase plus planned remaining steps
  string   ph;
  string   plan[$];
  int      cnt;
  bit      m_ill;

  function automatic bit is_mem(input string p);
    return (p == "FETCH") || (p == "MREAD") || (p == "MWRITE");
  endfunction

  function automatic logic [16:0] model_out(input bit r, input bit d);
    bit t;
    if (r) return 17'(m_ill);
    t = is_mem(ph) && !d && (cnt == LIMIT - 1);
    case (ph)
      "FETCH":  return ov(0, 2'b01, 2'b00, d, 0, 0, 0, 1, 0, d, 0, 0, 0, t, m_ill);
      "DECODE": return ov(0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_ill);
      "REXEC":  return ov(1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_ill);
      "RWB":    return ov(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, m_ill);
      "IEXEC", "MADDR":
                return ov(1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, m_ill);
      "IWB":    return ov(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, m_ill);
      "MREAD":  return ov(0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, t, m_ill);
      "LWB":    return ov(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, m_ill);
      "MWRITE": return ov(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, t, m_ill);
      "BRANCH": return ov(1, 2'b00, 2'b01, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, m_ill);
      default:  return 17'(m_ill);
    endcase
  endfunction

  task automatic advance();
    if (ph == "FETCH") ph = "DECODE";
    else if (plan.size() > 0) ph = plan.pop_front();
    else ph = "FETCH";
  endtask

  task automatic model_step(input bit r, input bit d, input logic [15:0] i);
    logic [3:0] op;
    if (r) begin
      ph = "FETCH"; cnt = 0; m_ill = 0; plan.delete();
      return;
    end
    if (is_mem(ph)) begin
      if (d) begin
        cnt = 0; advance();
      end else if (cnt == LIMIT - 1) begin
        cnt = 0; plan.delete(); ph = "FETCH";
      end else begin
        cnt++;
      end
    end else if (ph == "DECODE") begin
      op = i[15:12];
      case (op)
        4'h0: plan = '{"REXEC", "RWB"};
        4'h1: plan = '{"MADDR", "MREAD", "LWB"};
        4'h2: plan = '{"MADDR", "MWRITE"};
        4'h3: plan = '{"BRANCH"};
        4'h4: plan = '{"IEXEC", "IWB"};
        default: plan.delete();
      endcase
`ifdef ILLEGAL_TRAP_EN
      if (op > 4'h4) begin
        ph = "TRAP"; m_ill = 1;
      end else advance();
`else
      advance();
`endif
    end else if (ph != "TRAP") begin
      advance();
    end
  endtask

  typedef struct {
    bit          r;
    bit          d;
    logic [15:0] i;
    logic [16:0] e;
    string       nm;
  } vec_t;
  vec_t tbl[$];

  initial begin
    bit          r, d;
    int          p;
    logic [15:0] ri;
    logic [16:0] e;

    V_ZERO     = '0;
    V_FETCH0   = ov(0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    V_FETCH1   = ov(0, 2'b01, 2'b00, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    V_FETCH_TO = ov(0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    V_DECODE   = ov(0, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    V_REXEC    = ov(1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    V_RWB      = ov(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    V_BRANCH   = ov(1, 2'b00, 2'b01, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    V_MADDR    = ov(1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    V_MREAD    = ov(0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    V_LWB      = ov(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    V_MWRITE   = ov(0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    V_ILL      = 17'h00001;

    tbl.push_back('{1'b1, 1'b1, 16'h0024, V_ZERO,   "reset_c0"});
    tbl.push_back('{1'b1, 1'b1, 16'h0024, V_ZERO,   "reset_c1"});
    tbl.push_back('{1'b0, 1'b0, 16'h0024, V_FETCH0, "fetch_wait"});
    tbl.push_back('{1'b0, 1'b1, 16'h0024, V_FETCH1, "r_fetch"});
    tbl.push_back('{1'b0, 1'b1, 16'h0024, V_DECODE, "r_decode"});
    tbl.push_back('{1'b0, 1'b1, 16'h0024, V_REXEC,  "r_rexec"});
    tbl.push_back('{1'b0, 1'b1, 16'h0024, V_RWB,    "r_rwb"});
    tbl.push_back('{1'b0, 1'b1, 16'h3FFE, V_FETCH1, "beq_fetch"});
    tbl.push_back('{1'b0, 1'b1, 16'h3FFE, V_DECODE, "beq_decode"});
    tbl.push_back('{1'b0, 1'b1, 16'h3FFE, V_BRANCH, "beq_branch"});
    tbl.push_back('{1'b0, 1'b1, 16'h1005, V_FETCH1, "lw_fetch"});
    tbl.push_back('{1'b0, 1'b1, 16'h1005, V_DECODE, "lw_decode"});
    tbl.push_back('{1'b0, 1'b1, 16'h1005, V_MADDR,  "lw_maddr"});
    tbl.push_back('{1'b0, 1'b0, 16'h1005, V_MREAD,  "lw_mread1"});
    tbl.push_back('{1'b0, 1'b0, 16'h1005, V_MREAD,  "lw_mread2"});
    tbl.push_back('{1'b0, 1'b1, 16'h1005, V_MREAD,  "lw_mread3"});
    tbl.push_back('{1'b0, 1'b1, 16'h1005, V_LWB,    "lw_lwb"});
    tbl.push_back('{1'b0, 1'b1, 16'hF000, V_FETCH1, "ill_fetch"});
    tbl.push_back('{1'b0, 1'b1, 16'hF000, V_DECODE, "ill_decode"});
`ifdef ILLEGAL_TRAP_EN
    tbl.push_back('{1'b0, 1'b1, 16'hF000, V_ILL,    "ill_trap1"});
    tbl.push_back('{1'b0, 1'b1, 16'h0024, V_ILL,    "ill_trap2"});
    tbl.push_back('{1'b1, 1'b1, 16'h0024, V_ZERO | V_ILL, "ill_reset"});
`else
    tbl.push_back('{1'b0, 1'b0, 16'hF000, V_FETCH0, "ill_nop1"});
    tbl.push_back('{1'b0, 1'b1, 16'h0024, V_FETCH1, "ill_nop2"});
    tbl.push_back('{1'b1, 1'b1, 16'h0024, V_ZERO,   "ill_reset"});
`endif
    tbl.push_back('{1'b0, 1'b0, 16'h0024, V_FETCH0, "post_reset"});

    rst = 1'b1; rdy = 1'b0; ins = '0;
    @(posedge clk); #1;
    foreach (tbl[k]) cyc(tbl[k].r, tbl[k].d, tbl[k].i, tbl[k].e, M_ALL, tbl[k].nm);

    // SW watchdog: timeout on the LIMIT-th MWRITE cycle, then FETCH
    cyc(1, 0, 16'h2000, V_ZERO, M_ALL, "sw_reset");
    cyc(0, 1, 16'h2000, V_FETCH1, M_ALL, "sw_fetch");
    cyc(0, 1, 16'h2000, V_DECODE, M_ALL, "sw_decode");
    cyc(0, 1, 16'h2000, V_MADDR, M_ALL, "sw_maddr");
    for (int k = 1; k < LIMIT; k++) cyc(0, 0, 16'h2000, V_MWRITE, M_ALL, "sw_wait");
    cyc(0, 0, 16'h2000, 17'h00002, M_TO, "sw_timeout");
    cyc(0, 0, 16'h2000, V_FETCH0, M_ALL, "sw_after_to");

    // FETCH watchdog restarts with a cleared count
    for (int k = 2; k < LIMIT; k++) cyc(0, 0, 16'h2000, V_FETCH0, M_ALL, "fetch_wait_n");
    cyc(0, 0, 16'h2000, V_FETCH_TO, M_ALL, "fetch_timeout");
    cyc(0, 0, 16'h2000, V_FETCH0, M_ALL, "fetch_restart");

    // LW: MemReady in the limit cycle completes normally
    cyc(0, 1, 16'h1234, V_FETCH1, M_ALL, "lwl_fetch");
    cyc(0, 1, 16'h1234, V_DECODE, M_ALL, "lwl_decode");
    cyc(0, 1, 16'h1234, V_MADDR, M_ALL, "lwl_maddr");
    for (int k = 1; k < LIMIT; k++) cyc(0, 0, 16'h1234, V_MREAD, M_ALL, "lwl_wait");
    cyc(0, 1, 16'h1234, V_MREAD, M_ALL, "lwl_limit_ready");
    cyc(0, 1, 16'h1234, V_LWB, M_ALL, "lwl_lwb");

    // Reset mid-instruction suppresses the write-back
    cyc(0, 1, 16'h0024, V_FETCH1, M_ALL, "mid_fetch");
    cyc(0, 1, 16'h0024, V_DECODE, M_ALL, "mid_decode");
    cyc(0, 1, 16'h0024, V_REXEC, M_ALL, "mid_rexec");
    cyc(1, 1, 16'h0024, V_ZERO, M_ALL, "mid_reset");
    cyc(0, 0, 16'h0024, V_FETCH0, M_ALL, "mid_refetch");

    // Randomized run against the reference model
    ph = "FETCH"; cnt = 0; m_ill = 0; plan.delete();
    p  = 85;
    ri = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      r = (n == 0) || ($urandom_range(0, 99) == 0);
      if (n % 40 == 0) p = ($urandom_range(0, 1) == 1) ? 85 : 3;
      d = ($urandom_range(0, 99) < p);
      if (ph == "FETCH") begin
        case ($urandom_range(0, 6))
          0: ri[15:12] = 4'h0;
          1: ri[15:12] = 4'h1;
          2: ri[15:12] = 4'h2;
          3: ri[15:12] = 4'h3;
          4: ri[15:12] = 4'h4;
          default: ri[15:12] = 4'($urandom_range(5, 15));
        endcase
        ri[11:0] = 12'($urandom);
      end
      rst = r; rdy = d; ins = ri;
      e = model_out(r, d);
      @(negedge clk);
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL rand cycle %0d phase %s: got %h expected %h", n, ph, act, e);
      end
      @(posedge clk);
      model_step(r, d, ri);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
